// File: rtl/sram_arbiter.sv
// Two-port SRAM arbiter: pixel reads (A) vs. write buffer (B),
// one transaction in flight, vblank selects priority, timeout abort.
module sram_arbiter #(
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vblank,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_address,
  output logic              a_ready,
  output logic [DATA_W-1:0] a_data,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_address,
  input  logic [DATA_W-1:0] b_data_write,
  output logic              b_ready,
  output logic [DATA_W-1:0] b_data,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] data_write,
  input  logic [DATA_W-1:0] data_read,
  input  logic              ready,
  output logic              grant,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_e;

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] a_data_q, a_data_d;
  logic [DATA_W-1:0] b_data_q, b_data_d;
  logic              a_rdy_q, a_rdy_d;
  logic              b_rdy_q, b_rdy_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              pick_b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      grant_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      a_data_q <= '0;
      b_data_q <= '0;
      a_rdy_q  <= 1'b0;
      b_rdy_q  <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      a_data_q <= a_data_d;
      b_data_q <= b_data_d;
      a_rdy_q  <= a_rdy_d;
      b_rdy_q  <= b_rdy_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    a_data_d = a_data_q;
    b_data_d = b_data_q;
    a_rdy_d  = 1'b0;
    b_rdy_d  = 1'b0;
    cnt_d    = cnt_q;
    err_d    = err_q;
    pick_b   = b_req && (!a_req || vblank);
    unique case (state_q)
      S_IDLE: begin
        if (a_req || b_req) begin
          grant_d = pick_b;
          we_d    = pick_b && b_we;
          addr_d  = pick_b ? b_address : a_address;
          if (pick_b) begin
            wdata_d = b_data_write;
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ready) begin
          state_d = S_IDLE;
          if (grant_q) begin
            b_rdy_d = 1'b1;
            if (!we_q) begin
              b_data_d = data_read;
            end
          end else begin
            a_rdy_d  = 1'b1;
            a_data_d = data_read;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
          // Abort: requester still gets its pulse, with zeroed data
          if (cnt_d == TO_LIM) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
            if (grant_q) begin
              b_rdy_d  = 1'b1;
              b_data_d = '0;
            end else begin
              a_rdy_d  = 1'b1;
              a_data_d = '0;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign read        = (state_q == S_ISSUE) && !we_q;
  assign write       = (state_q == S_ISSUE) && we_q;
  assign busy        = (state_q != S_IDLE);
  assign address     = addr_q;
  assign data_write  = wdata_q;
  assign grant       = grant_q;
  assign timeout_err = err_q;
  assign a_ready     = a_rdy_q;
  assign b_ready     = b_rdy_q;
  assign a_data      = a_data_q;
  assign b_data      = b_data_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: vector table plus
// hand sequences for priority, timeout, reset and back-to-back.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        vblank;
  logic        a_req;
  logic [17:0] a_address;
  logic        a_ready;
  logic [15:0] a_data;
  logic        b_req;
  logic        b_we;
  logic [17:0] b_address;
  logic [15:0] b_data_write;
  logic        b_ready;
  logic [15:0] b_data;
  logic [17:0] address;
  logic        read;
  logic        write;
  logic [15:0] data_write;
  logic [15:0] data_read;
  logic        ready;
  logic        grant;
  logic        busy;
  logic        timeout_err;

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_a = '0;
  logic [15:0] exp_b = '0;
  logic        exp_err = 1'b0;

  sram_arbiter dut (
    .clk(clk), .reset(reset), .vblank(vblank),
    .a_req(a_req), .a_address(a_address),
    .a_ready(a_ready), .a_data(a_data),
    .b_req(b_req), .b_we(b_we), .b_address(b_address),
    .b_data_write(b_data_write),
    .b_ready(b_ready), .b_data(b_data),
    .address(address), .read(read), .write(write),
    .data_write(data_write), .data_read(data_read),
    .ready(ready), .grant(grant), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          vb;
    bit          ar;
    bit          br;
    bit          bwe;
    logic [17:0] aad;
    logic [17:0] bad;
    logic [15:0] bwd;
    int          k;
    logic [15:0] rd;
    bit          eg;
    bit          ewe;
    logic [17:0] ead;
    logic [15:0] ewd;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Starts at the negedge where the requests were driven (IDLE)
  task automatic txn(input bit eb, input bit ewe,
                     input logic [17:0] eaddr, input logic [15:0] ewd,
                     input int k, input logic [15:0] rdata,
                     input bit flip_vb, input bit keep);
    @(negedge clk);
    ready = 1'b0;
    chk("strobe_rd", read, !ewe);
    chk("strobe_wr", write, ewe);
    chk("busy_issue", busy, 1);
    chk("grant_issue", grant, eb);
    chk("addr_issue", address, eaddr);
    if (ewe) chk("wdata", data_write, ewd);
    for (int j = 1; j <= k; j++) begin
      @(negedge clk);
      if (j == 1) begin
        chk("strobe_off", read | write, 0);
        chk("busy_wait", busy, 1);
        if (flip_vb) vblank = 1'b1;
      end
      chk("addr_hold", address, eaddr);
      if (j == k) begin
        ready = 1'b1;
        data_read = rdata;
      end
    end
    @(negedge clk);
    ready = 1'b0;
    data_read = 16'hDEAD;
    if (!ewe) begin
      if (eb) exp_b = rdata;
      else exp_a = rdata;
    end
    chk("a_ready", a_ready, !eb);
    chk("b_ready", b_ready, eb);
    chk("a_data", a_data, exp_a);
    chk("b_data", b_data, exp_b);
    chk("grant_done", grant, eb);
    chk("busy_done", busy, 0);
    chk("timeout_err", timeout_err, exp_err);
    if (!keep) begin
      if (eb) b_req = 1'b0;
      else a_req = 1'b0;
    end
  endtask

  task automatic idle_chk();
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_strobe", read | write, 0);
    chk("idle_ardy", a_ready, 0);
    chk("idle_brdy", b_ready, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 1, 0, 0, 18'h00100, 18'h0, 16'h0, 2, 16'hBEEF,
               0, 0, 18'h00100, 16'h0};
    tbl[1] = '{1, 1, 1, 1, 18'h00200, 18'h3FFFF, 16'h1234, 1, 16'h0,
               1, 1, 18'h3FFFF, 16'h1234};
    tbl[2] = '{0, 1, 1, 0, 18'h00300, 18'h00400, 16'h0, 3, 16'h1111,
               0, 0, 18'h00300, 16'h0};
    tbl[3] = '{1, 0, 1, 0, 18'h0, 18'h00ABC, 16'h0, 4, 16'h5A5A,
               1, 0, 18'h00ABC, 16'h0};
    tbl[4] = '{0, 0, 1, 1, 18'h0, 18'h00005, 16'hCAFE, 1, 16'h0,
               1, 1, 18'h00005, 16'hCAFE};
    tbl[5] = '{1, 1, 0, 0, 18'h12345, 18'h0, 16'h0, 1, 16'h0F0F,
               0, 0, 18'h12345, 16'h0};
    tbl[6] = '{0, 1, 1, 1, 18'h3FFFF, 18'h00001, 16'h0, 15, 16'h8001,
               0, 0, 18'h3FFFF, 16'h0};
    tbl[7] = '{1, 1, 1, 0, 18'h00007, 18'h00008, 16'h0, 2, 16'h7777,
               1, 0, 18'h00008, 16'h0};

    reset = 1'b0;
    vblank = 1'b0;
    a_req = 1'b0;
    a_address = '0;
    b_req = 1'b0;
    b_we = 1'b0;
    b_address = '0;
    b_data_write = '0;
    data_read = '0;
    ready = 1'b0;
    #1;
    chk("rst_read", read, 0);
    chk("rst_write", write, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_ardy", a_ready, 0);
    chk("rst_brdy", b_ready, 0);
    chk("rst_addr", address, 0);
    chk("rst_wdata", data_write, 0);
    chk("rst_adata", a_data, 0);
    chk("rst_bdata", b_data, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ready = 1'b1;
    idle_chk();
    ready = 1'b0;

    for (int i = 0; i < 8; i++) begin
      vblank = tbl[i].vb;
      a_req = tbl[i].ar;
      b_req = tbl[i].br;
      b_we = tbl[i].bwe;
      a_address = tbl[i].aad;
      b_address = tbl[i].bad;
      b_data_write = tbl[i].bwd;
      txn(tbl[i].eg, tbl[i].ewe, tbl[i].ead, tbl[i].ewd,
          tbl[i].k, tbl[i].rd, 0, 0);
      a_req = 1'b0;
      b_req = 1'b0;
      idle_chk();
    end

    // Blanking: B write wins, then A is served back-to-back
    vblank = 1'b1;
    a_req = 1'b1;
    a_address = 18'h00111;
    b_req = 1'b1;
    b_we = 1'b1;
    b_address = 18'h3FFFF;
    b_data_write = 16'h1234;
    txn(1, 1, 18'h3FFFF, 16'h1234, 2, 16'h0, 0, 0);
    txn(0, 0, 18'h00111, 16'h0, 1, 16'hABCD, 0, 0);
    idle_chk();

    // Active video: A wins; vblank flips mid-WAIT without effect
    vblank = 1'b0;
    a_req = 1'b1;
    a_address = 18'h00333;
    b_req = 1'b1;
    b_we = 1'b0;
    b_address = 18'h00222;
    txn(0, 0, 18'h00333, 16'h0, 2, 16'h2468, 1, 0);
    txn(1, 0, 18'h00222, 16'h0, 1, 16'h1357, 0, 0);
    idle_chk();

    // Held a_req: four transactions, stray ready in each IDLE gap
    vblank = 1'b0;
    a_req = 1'b1;
    a_address = 18'h00444;
    for (int i = 0; i < 4; i++) begin
      txn(0, 0, 18'h00444, 16'h0, 1, 16'h0100 + 16'(i), 0, i < 3);
      if (i < 3) begin
        ready = 1'b1;
        data_read = 16'hFFFF;
      end
    end
    idle_chk();
    chk("stray_adata", a_data, 16'h0103);

    // Timeout on a B read with no controller response
    b_req = 1'b1;
    b_we = 1'b0;
    b_address = 18'h00099;
    @(negedge clk);
    chk("to_strobe", read, 1);
    for (int j = 1; j <= 15; j++) begin
      @(negedge clk);
      chk("to_busy", busy, 1);
      chk("to_brdy_early", b_ready, 0);
      chk("to_err_early", timeout_err, 0);
    end
    @(negedge clk);
    b_req = 1'b0;
    exp_b = 16'h0;
    exp_err = 1'b1;
    chk("to_brdy", b_ready, 1);
    chk("to_bdata", b_data, 16'h0);
    chk("to_err", timeout_err, 1);
    chk("to_busy_end", busy, 0);
    idle_chk();
    chk("to_err_sticky", timeout_err, 1);
    a_req = 1'b1;
    a_address = 18'h00050;
    txn(0, 0, 18'h00050, 16'h0, 1, 16'h4242, 0, 0);
    idle_chk();

    // Reset during WAIT aborts silently; pending request served after
    a_req = 1'b1;
    a_address = 18'h00555;
    @(negedge clk);
    chk("rw_strobe", read, 1);
    @(negedge clk);
    chk("rw_busy_pre", busy, 1);
    reset = 1'b0;
    #1;
    chk("rw_read", read, 0);
    chk("rw_write", write, 0);
    chk("rw_busy", busy, 0);
    chk("rw_err", timeout_err, 0);
    chk("rw_adata", a_data, 0);
    @(negedge clk);
    chk("rw_ardy", a_ready, 0);
    chk("rw_brdy", b_ready, 0);
    reset = 1'b1;
    exp_a = '0;
    exp_b = '0;
    exp_err = 1'b0;
    txn(0, 0, 18'h00555, 16'h0, 2, 16'h9999, 0, 0);
    idle_chk();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
